mem_port_arbiter: RTL and testbench

- Shares one single-read-port / single-write-port `memory` instance between the core's instruction-fetch port and data port.
- Enables a unified instruction+data memory behind `riscv_core`.
- Arbitrates the one read port, passes data writes straight to the write port, and routes each synchronous read response back to the requester that issued it.
- Sits between `riscv_core` and `memory`.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_grant2.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 84 ++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_BYTE = 2'b01;
    localparam logic [1:0] WR_HALF = 2'b10;
    localparam logic [1:0] WR_WORD = 2'b11;

endpackage

// File: rtl/arb_grant2.sv
// Two-way read-port grant: data priority with a starvation guard for the
// instruction side, or round-robin when ARB_ROUND_ROBIN_EN is defined.
module arb_grant2
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic req_d,
    input  logic blk_i,
    output logic gnt_i,
    output logic gnt_d
);

    logic i_wins;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 favours data, 1 favours instruction; flips on every contested grant.
    logic rr_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_i <= 1'b0;
        else if (req_i && req_d)
            rr_i <= ~rr_i;
    end

    assign i_wins = rr_i;
`else
    logic [3:0] wait_cnt;

    assign i_wins = (wait_cnt >= 4'(MAX_WAIT));

    // A hazard stall can leave the count above MAX_WAIT; saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= 4'd0;
        else if (gnt_i)
            wait_cnt <= 4'd0;
        else if (req_i && wait_cnt != 4'hF)
            wait_cnt <= wait_cnt + 4'd1;
    end
`endif

    always_comb begin
        gnt_i = req_i && !blk_i && (!req_d || i_wins);
        gnt_d = req_d && !(req_i && !blk_i && i_wins);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one read port and one write port of a synchronous memory between the
// instruction and data requesters. Optional round-robin via ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [1:0]        d_req_wr,
    input  logic [DATA_W-1:0] d_req_wr_data,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [1:0]        mem_wr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data
);

    logic   d_rd, d_wr, raw_hazard;
    logic   gnt_i, gnt_d;
    owner_e owner, owner_nxt;

    assign d_rd = d_req_valid && (d_req_wr == WR_NONE);
    assign d_wr = d_req_valid && (d_req_wr != WR_NONE);

    // Only the instruction side can read while data writes; hold it off one
    // cycle on a word match so it observes the freshly written value.
    assign raw_hazard = d_wr && i_req_valid &&
                        (i_req_addr[ADDR_W-1:2] == d_req_addr[ADDR_W-1:2]);

    arb_grant2 #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (i_req_valid),
        .req_d (d_rd),
        .blk_i (raw_hazard),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    assign i_req_ready = gnt_i;
    assign d_req_ready = gnt_d || d_wr;

    assign mem_rd_addr = gnt_d ? d_req_addr : i_req_addr;
    assign mem_wr      = d_wr ? d_req_wr : WR_NONE;
    assign mem_wr_addr = d_req_addr;
    assign mem_wr_data = d_req_wr_data;

    always_comb begin
        owner_nxt = OWN_NONE;
        if (gnt_d)
            owner_nxt = OWN_D;
        else if (gnt_i)
            owner_nxt = OWN_I;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            owner <= OWN_NONE;
        else
            owner <= owner_nxt;
    end

    // Memory data is already registered; steering it by owner adds no cycle.
    assign i_rsp_valid = (owner == OWN_I);
    assign d_rsp_valid = (owner == OWN_D);
    assign i_rsp_data  = (owner == OWN_I) ? mem_rd_data : '0;
    assign d_rsp_data  = (owner == OWN_D) ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous memory
// and per-port expected-response queues.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid, i_req_ready;
    logic [31:0] i_req_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        d_req_valid, d_req_ready;
    logic [31:0] d_req_addr;
    logic [1:0]  d_req_wr;
    logic [31:0] d_req_wr_data;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [1:0]  mem_wr;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    int passed = 0;
    int total  = 0;

    logic [31:0] i_q[$];
    logic [31:0] d_q[$];
    logic [31:0] ref_w[int];

    bit          wrote[0:1023];
    logic [31:0] wval[0:1023];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (i_req_valid),
        .i_req_ready   (i_req_ready),
        .i_req_addr    (i_req_addr),
        .i_rsp_valid   (i_rsp_valid),
        .i_rsp_data    (i_rsp_data),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_req_addr    (d_req_addr),
        .d_req_wr      (d_req_wr),
        .d_req_wr_data (d_req_wr_data),
        .d_rsp_valid   (d_rsp_valid),
        .d_rsp_data    (d_rsp_data),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .mem_wr        (mem_wr),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data)
    );

    function automatic logic [31:0] init_val(input int idx);
        return 32'h5A00_0000 ^ (idx * 32'h0001_0103);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] wr,
                                          input logic [1:0] lo, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        case (wr)
            2'b01:   r[8*lo +: 8]     = wd[7:0];
            2'b10:   r[16*lo[1] +: 16] = wd[15:0];
            2'b11:   r = wd;
            default: r = old;
        endcase
        return r;
    endfunction

    // Memory: 1-cycle registered read, read-before-write on the same edge.
    always @(posedge clk) begin
        mem_rd_data <= wrote[mem_rd_addr[11:2]] ? wval[mem_rd_addr[11:2]]
                                                : init_val(int'(mem_rd_addr[11:2]));
        if (mem_wr != 2'b00) begin
            wval[mem_wr_addr[11:2]]  <= merge(wrote[mem_wr_addr[11:2]] ? wval[mem_wr_addr[11:2]]
                                                  : init_val(int'(mem_wr_addr[11:2])),
                                              mem_wr, mem_wr_addr[1:0], mem_wr_data);
            wrote[mem_wr_addr[11:2]] <= 1'b1;
        end
    end

    function automatic logic [31:0] ref_rd(input int idx);
        return ref_w.exists(idx) ? ref_w[idx] : init_val(idx);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One cycle: check responses due now, check readies, record accepts.
    task automatic step(input string tag, input logic exp_ir, input logic exp_dr);
        logic [31:0] e;
        int          idx;
        @(negedge clk);
        chk({tag, ".i_rsp_valid"}, 32'(i_rsp_valid), 32'(i_q.size() != 0));
        if (i_q.size() != 0) begin
            e = i_q.pop_front();
            chk({tag, ".i_rsp_data"}, i_rsp_data, e);
        end
        chk({tag, ".d_rsp_valid"}, 32'(d_rsp_valid), 32'(d_q.size() != 0));
        if (d_q.size() != 0) begin
            e = d_q.pop_front();
            chk({tag, ".d_rsp_data"}, d_rsp_data, e);
        end
        chk({tag, ".i_req_ready"}, 32'(i_req_ready), 32'(exp_ir));
        chk({tag, ".d_req_ready"}, 32'(d_req_ready), 32'(exp_dr));
        if (i_req_valid && exp_ir)
            i_q.push_back(ref_rd(int'(i_req_addr[11:2])));
        if (d_req_valid && exp_dr && d_req_wr == 2'b00)
            d_q.push_back(ref_rd(int'(d_req_addr[11:2])));
        if (d_req_valid && exp_dr && d_req_wr != 2'b00) begin
            idx = int'(d_req_addr[11:2]);
            ref_w[idx] = merge(ref_rd(idx), d_req_wr, d_req_addr[1:0], d_req_wr_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        i_req_valid = 1'b0; i_req_addr = '0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_wr = 2'b00; d_req_wr_data = '0;
        #2;
        chk("rst.i_rsp_valid", 32'(i_rsp_valid), 32'd0);
        chk("rst.d_rsp_valid", 32'(d_rsp_valid), 32'd0);
        chk("rst.i_rsp_data", i_rsp_data, 32'd0);
        chk("rst.d_rsp_data", d_rsp_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Instruction-only streaming reads.
        i_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_req_addr = 32'(k * 4);
            step("iseq", 1'b1, 1'b0);
        end
        i_req_valid = 1'b0;
        step("iseq_end", 1'b0, 1'b0);

        // Read conflict: data wins by default.
        i_req_valid = 1'b1; i_req_addr = 32'h10;
        d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_wr = 2'b00;
        #1 chk("conf.mem_rd_addr", mem_rd_addr, 32'h200);
        step("conf1", 1'b0, 1'b1);
        d_req_valid = 1'b0;
        step("conf2", 1'b1, 1'b0);
        i_req_valid = 1'b0;
        step("conf3", 1'b0, 1'b0);

        // Starvation guard: four stalls, then instruction wins once.
        i_req_valid = 1'b1; i_req_addr = 32'h80;
        d_req_valid = 1'b1; d_req_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            step("starve", 1'b0, 1'b1);
            d_req_addr = d_req_addr + 32'd4;
        end
        step("starve_win", 1'b1, 1'b0);
        i_req_valid = 1'b0;
        step("starve_d", 1'b0, 1'b1);
        d_req_valid = 1'b0;
        step("starve_end", 1'b0, 1'b0);

        // Read-after-write hazard on the same word.
        i_req_valid = 1'b1; i_req_addr = 32'h20;
        d_req_valid = 1'b1; d_req_addr = 32'h20; d_req_wr = 2'b11; d_req_wr_data = 32'hDEADBEEF;
        #1 chk("raw.mem_wr", 32'(mem_wr), 32'd3);
        chk("raw.mem_wr_data", mem_wr_data, 32'hDEADBEEF);
        step("raw1", 1'b0, 1'b1);
        d_req_valid = 1'b0; d_req_wr = 2'b00;
        step("raw2", 1'b1, 1'b0);
        i_req_valid = 1'b0;
        step("raw3", 1'b0, 1'b0);

        // Instruction read alongside an unrelated byte write.
        i_req_valid = 1'b1; i_req_addr = 32'h24;
        d_req_valid = 1'b1; d_req_addr = 32'h101; d_req_wr = 2'b01; d_req_wr_data = 32'h0000_00C3;
        #1 chk("wrb.mem_wr", 32'(mem_wr), 32'd1);
        chk("wrb.mem_wr_addr", mem_wr_addr, 32'h101);
        step("wrb1", 1'b1, 1'b1);
        i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_wr = 2'b00;
        #1 chk("idle.mem_wr", 32'(mem_wr), 32'd0);
        step("wrb2", 1'b0, 1'b0);

        // Byte write read back through the data port.
        d_req_valid = 1'b1; d_req_addr = 32'h100;
        step("rdb1", 1'b0, 1'b1);
        d_req_valid = 1'b0;
        step("rdb2", 1'b0, 1'b0);

        // Reset while a data response is in flight drops it.
        d_req_valid = 1'b1; d_req_addr = 32'h40;
        step("rst_rd", 1'b0, 1'b1);
        d_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst.d_rsp_valid", 32'(d_rsp_valid), 32'd0);
        chk("midrst.d_rsp_data", d_rsp_data, 32'd0);
        d_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("post_rst", 1'b0, 1'b0);
        i_req_valid = 1'b1; i_req_addr = 32'h44;
        step("post_rst_i", 1'b1, 1'b0);
        i_req_valid = 1'b0;
        step("post_rst_end", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
